// File: rtl/cuenta1.sv
// Serial ones-counter: counts the '1' bits of entrada, one bit per clock.
// The two-process FSM sequences a load / count / done run; start is an async restart.
module cuenta1 #(
  parameter int WIDTH     = 3,
  parameter int OUT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 start,
  input  logic [WIDTH-1:0]     entrada,
  output logic [OUT_WIDTH-1:0] salida,
  output logic                 fin
);

  localparam int BC_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_sr;
  logic [BC_W-1:0]      r_bc;
  logic [OUT_WIDTH-1:0] r_acc;

  always_ff @(posedge clk or posedge start) begin
    if (start) r_state <= LOAD;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD:    w_next = COUNT;
      COUNT:   if (r_bc == BC_W'(1)) w_next = DONE;
      DONE:    w_next = DONE;
      default: w_next = LOAD;
    endcase
  end

  // The bit counter tracks how many bits are still to be examined.
  always_ff @(posedge clk or posedge start) begin
    if (start) begin
      r_sr  <= '0;
      r_bc  <= '0;
      r_acc <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          r_sr  <= entrada;
          r_acc <= '0;
          r_bc  <= BC_W'(WIDTH);
        end
        COUNT: begin
          r_acc <= r_acc + OUT_WIDTH'(r_sr[0]);
          r_sr  <= r_sr >> 1;
          r_bc  <= r_bc - BC_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign salida = r_acc;
  assign fin    = (r_state == DONE);

endmodule

// File: tb/tb_cuenta1.sv
// Bench for cuenta1: directed and random runs against a bit-counting reference model.
module tb_cuenta1;

  logic       clk;
  logic       start;
  logic [2:0] entrada;
  logic [3:0] salida;
  logic       fin;

  int checks   = 0;
  int failures = 0;

  cuenta1 #(.WIDTH(3), .OUT_WIDTH(4)) dut (
    .clk     (clk),
    .start   (start),
    .entrada (entrada),
    .salida  (salida),
    .fin     (fin)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Ones among the lowest k bits of v: the count expected after k counting edges.
  function automatic int ones_low(input logic [2:0] v, input int k);
    int n = 0;
    for (int i = 0; i < k; i++) if (v[i]) n++;
    return n;
  endfunction

  // One complete run: restart, release on a falling edge, then load, count, hold.
  task automatic run(input logic [2:0] val, input bit scramble, input int hold);
    start = 1'b1;
    #1;
    chk("reset_salida", 32'(salida), 0);
    chk("reset_fin", 32'(fin), 0);
    @(negedge clk);
    entrada = val;
    start   = 1'b0;
    @(posedge clk); #1;
    chk("load_salida", 32'(salida), 0);
    chk("load_fin", 32'(fin), 0);
    for (int k = 1; k <= 3; k++) begin
      if (scramble) entrada = 3'($urandom);
      @(posedge clk); #1;
      chk("count_salida", 32'(salida), 32'(ones_low(val, k)));
      chk("count_fin", 32'(fin), (k == 3) ? 1 : 0);
    end
    for (int h = 0; h < hold; h++) begin
      entrada = 3'($urandom);
      @(posedge clk); #1;
      chk("hold_salida", 32'(salida), 32'(ones_low(val, 3)));
      chk("hold_fin", 32'(fin), 1);
    end
  endtask

  initial begin
    start   = 1'b1;
    entrada = 3'b101;
    #5;
    chk("por_salida", 32'(salida), 0);
    chk("por_fin", 32'(fin), 0);

    // 101 with a long hold: fin at t=90, held through t=400
    run(3'b101, 1'b0, 16);
    run(3'b000, 1'b0, 2);
    run(3'b111, 1'b0, 2);

    // entrada changes 101 -> 010 during the count
    start = 1'b1;
    @(negedge clk);
    entrada = 3'b101;
    start   = 1'b0;
    @(posedge clk); #1;
    entrada = 3'b010;
    repeat (3) @(posedge clk);
    #1;
    chk("latched_salida", 32'(salida), 2);
    chk("latched_fin", 32'(fin), 1);

    // asynchronous restart in the middle of a count
    start = 1'b1;
    @(negedge clk);
    entrada = 3'b111;
    start   = 1'b0;
    repeat (3) @(posedge clk);
    #5;
    chk("mid_pre_salida", 32'(salida), 2);
    start = 1'b1;
    #1;
    chk("abort_salida", 32'(salida), 0);
    chk("abort_fin", 32'(fin), 0);
    run(3'b011, 1'b0, 1);

    // random runs with entrada scrambled after loading
    for (int r = 0; r < 20; r++) run(3'($urandom), 1'b1, 1 + int'($urandom_range(0, 3)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
